// File: rtl/vend_pkg.sv
// vend_pkg: shared types and helpers for the parametrised vending controller.
// Holds the FSM state enum, the status code enum, the default coin values and
// item costs, and the coin-value summation helper.
package vend_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CHECK    = 3'd1,
      DISPENSE = 3'd2,
      ROLLBACK = 3'd3,
      DONE     = 3'd4
   } vend_state_t;

   typedef enum logic [1:0] {
      ST_OK       = 2'd0,
      ST_SHORT    = 2'd1,
      ST_NOCHANGE = 2'd2,
      ST_CANCEL   = 2'd3
   } vend_status_t;

   // Denomination values, index 0 (highest value) in the most significant slice.
   localparam logic [31:0] COIN_VAL_DEF  = {8'd50, 8'd10, 8'd5, 8'd1};
   // Item costs, item 0 in the most significant slice.
   localparam logic [23:0] ITEM_COST_DEF = {8'd8, 8'd15, 8'd22};

   // Widest configuration the summation helper accepts.
   localparam int SUM_MAX_N  = 16;
   localparam int SUM_MAX_CW = 8;
   localparam int SUM_MAX_VW = 32;

   // Sum of count x value over n denominations. Both vectors use the same
   // slice order, so the pairing of slices does not depend on that order.
   function automatic logic [31:0] coin_sum(
      input logic [SUM_MAX_N*SUM_MAX_CW-1:0] cnts,
      input logic [SUM_MAX_N*SUM_MAX_VW-1:0] vals,
      input int                              n,
      input int                              cw,
      input int                              vw
   );
      logic [31:0] acc;
      logic [31:0] cnt;
      logic [31:0] val;
      acc = 32'd0;
      for (int i = 0; i < SUM_MAX_N; i++) begin
         cnt = 32'd0;
         val = 32'd0;
         if (i < n) begin
            for (int b = 0; b < SUM_MAX_CW; b++) begin
               cnt[b] = (b < cw) ? cnts[i*cw+b] : 1'b0;
            end
            for (int b = 0; b < SUM_MAX_VW; b++) begin
               val[b] = (b < vw) ? vals[i*vw+b] : 1'b0;
            end
         end
         acc = acc + cnt * val;
      end
      return acc;
   endfunction

endpackage

// File: rtl/vend_coin_stock.sv
// vend_coin_stock: stock counter for one denomination. Saturating add of the
// inserted count, single-coin decrement on issue, and the rollback step that
// returns issued coins and removes the refunded inserted coins.
module vend_coin_stock
   import vend_pkg::*;
#(
   parameter int IN_W  = 2,
   parameter int CNT_W = 3,
   parameter int INIT  = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_add_en,
   input  logic [IN_W-1:0]  i_add_cnt,
   input  logic             i_dec,
   input  logic             i_rb_en,
   input  logic [CNT_W-1:0] i_rb_add,
   input  logic [IN_W-1:0]  i_rb_sub,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W:0]   w_add_sum;
   logic [CNT_W:0]   w_rb_sum;

   // One extra bit exposes the carry used for saturation.
   assign w_add_sum = {1'b0, r_cnt} + (CNT_W+1)'(i_add_cnt);
   // Stock after accept already contains the inserted coins, so this never underflows.
   assign w_rb_sum  = {1'b0, r_cnt} + {1'b0, i_rb_add} - (CNT_W+1)'(i_rb_sub);

   // Counter update: reset load, accept add, issue decrement, rollback restore.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= CNT_W'(INIT);
      end else if (i_add_en) begin
         r_cnt <= w_add_sum[CNT_W] ? {CNT_W{1'b1}} : w_add_sum[CNT_W-1:0];
      end else if (i_dec) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end else if (i_rb_en) begin
         r_cnt <= w_rb_sum[CNT_W-1:0];
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/vend_multi_ctrl.sv
// vend_multi_ctrl: parametrised vending controller with request handshake,
// status code, exact refund when change cannot be made, and a change-check
// property output p. Optional macro VEND_CANCEL_EN adds the cancel input.
// Packed per-denomination vectors carry denomination 0 in the top slice.
module vend_multi_ctrl
   import vend_pkg::*;
#(
   parameter int                          NUM_COIN   = 4,
   parameter int                          NUM_ITEM   = 3,
   parameter int                          IN_W       = 2,
   parameter int                          CNT_W      = 3,
   parameter int                          VAL_W      = 8,
   parameter logic [NUM_COIN*VAL_W-1:0]   COIN_VAL   = COIN_VAL_DEF,
   parameter logic [NUM_ITEM*VAL_W-1:0]   ITEM_COST  = ITEM_COST_DEF,
   parameter int                          INIT_STOCK = 2,
   localparam int                         ITEM_W     = (NUM_ITEM > 1) ? $clog2(NUM_ITEM) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ITEM_W-1:0]         req_item,
   input  logic [NUM_COIN*IN_W-1:0]  coin_in,
`ifdef VEND_CANCEL_EN
   input  logic                      cancel,
`endif
   output logic                      vend_valid,
   output logic                      item_ok,
   output logic [ITEM_W-1:0]         item_out,
   output logic [NUM_COIN*CNT_W-1:0] coin_out,
   output logic [1:0]                status,
   output logic                      p
);

   localparam int                IDX_W    = (NUM_COIN > 1) ? $clog2(NUM_COIN) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_COIN-1);
   localparam int                SUM_CB   = SUM_MAX_N*SUM_MAX_CW;
   localparam int                SUM_VB   = SUM_MAX_N*SUM_MAX_VW;

   vend_state_t               r_state;
   vend_status_t              r_status;
   logic [IDX_W-1:0]          r_idx;
   logic [VAL_W-1:0]          r_change;
   logic [VAL_W-1:0]          r_exp;
   logic [VAL_W-1:0]          r_in_val;
   logic [ITEM_W-1:0]         r_item;
   logic [NUM_COIN*IN_W-1:0]  r_coin_in;
   logic [NUM_COIN*CNT_W-1:0] r_coin_out;
   logic                      r_item_ok;
   logic [ITEM_W-1:0]         r_item_out;
   logic                      r_vend_valid;
   logic                      r_p;

   logic [NUM_COIN*CNT_W-1:0] w_stock_flat;
   logic [VAL_W-1:0]          w_in_sum;
   logic [VAL_W-1:0]          w_lat_sum;
   logic [VAL_W-1:0]          w_out_sum;
   logic [VAL_W-1:0]          w_cur_val;
   logic                      w_cur_nz;
   logic [VAL_W-1:0]          w_cost;
   logic                      w_accept;
   logic                      w_cancel;
   logic                      w_issue;
   logic                      w_rollback;

`ifdef VEND_CANCEL_EN
   assign w_cancel = cancel && ((r_state == CHECK) || (r_state == DISPENSE));
`else
   assign w_cancel = 1'b0;
`endif

   // Money values wrap in VAL_W by design.
   assign w_in_sum  = VAL_W'(coin_sum(SUM_CB'(coin_in),    SUM_VB'(COIN_VAL), NUM_COIN, IN_W,  VAL_W));
   assign w_lat_sum = VAL_W'(coin_sum(SUM_CB'(r_coin_in),  SUM_VB'(COIN_VAL), NUM_COIN, IN_W,  VAL_W));
   assign w_out_sum = VAL_W'(coin_sum(SUM_CB'(r_coin_out), SUM_VB'(COIN_VAL), NUM_COIN, CNT_W, VAL_W));

   // Select value and stock of the current denomination and the cost of the latched item.
   always_comb begin
      w_cur_val = '0;
      w_cur_nz  = 1'b0;
      w_cost    = '0;
      for (int i = 0; i < NUM_COIN; i++) begin
         w_cur_val = (r_idx == IDX_W'(i)) ? COIN_VAL[(NUM_COIN-1-i)*VAL_W +: VAL_W] : w_cur_val;
         w_cur_nz  = (r_idx == IDX_W'(i)) ? (|w_stock_flat[(NUM_COIN-1-i)*CNT_W +: CNT_W]) : w_cur_nz;
      end
      for (int i = 0; i < NUM_ITEM; i++) begin
         w_cost = (r_item == ITEM_W'(i)) ? ITEM_COST[(NUM_ITEM-1-i)*VAL_W +: VAL_W] : w_cost;
      end
   end

   assign w_accept   = (r_state == IDLE) && req_valid;
   assign w_issue    = (r_state == DISPENSE) && !w_cancel && (r_change >= w_cur_val) && w_cur_nz;
   assign w_rollback = (r_state == ROLLBACK);

   for (genvar g = 0; g < NUM_COIN; g++) begin : g_stock
      vend_coin_stock #(
         .IN_W  (IN_W),
         .CNT_W (CNT_W),
         .INIT  (INIT_STOCK)
      ) u_stock (
         .i_clk     (clk),
         .i_reset   (reset),
         .i_add_en  (w_accept),
         .i_add_cnt (coin_in[(NUM_COIN-1-g)*IN_W +: IN_W]),
         .i_dec     (w_issue && (r_idx == IDX_W'(g))),
         .i_rb_en   (w_rollback),
         .i_rb_add  (r_coin_out[(NUM_COIN-1-g)*CNT_W +: CNT_W]),
         .i_rb_sub  (r_coin_in[(NUM_COIN-1-g)*IN_W +: IN_W]),
         .o_cnt     (w_stock_flat[(NUM_COIN-1-g)*CNT_W +: CNT_W])
      );
   end

   // Main FSM with registered result outputs; vend_valid and p pulse for the DONE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_status     <= ST_OK;
         r_idx        <= '0;
         r_change     <= '0;
         r_exp        <= '0;
         r_in_val     <= '0;
         r_item       <= '0;
         r_coin_in    <= '0;
         r_coin_out   <= '0;
         r_item_ok    <= 1'b0;
         r_item_out   <= '0;
         r_vend_valid <= 1'b0;
         r_p          <= 1'b0;
      end else begin
         r_vend_valid <= 1'b0;
         r_p          <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_coin_in  <= coin_in;
                  r_item     <= req_item;
                  r_in_val   <= w_in_sum;
                  r_coin_out <= '0;
                  r_state    <= CHECK;
               end else begin
                  r_state    <= IDLE;
               end
            end
            CHECK: begin
               if (w_cancel) begin
                  r_status <= ST_CANCEL;
                  r_state  <= ROLLBACK;
               end else begin
                  if (r_in_val < w_cost) begin
                     r_change   <= r_in_val;
                     r_exp      <= r_in_val;
                     r_item_ok  <= 1'b0;
                     r_item_out <= '0;
                     r_status   <= ST_SHORT;
                  end else begin
                     r_change   <= r_in_val - w_cost;
                     r_exp      <= r_in_val - w_cost;
                     r_item_ok  <= 1'b1;
                     r_item_out <= r_item;
                     r_status   <= ST_OK;
                  end
                  r_idx   <= '0;
                  r_state <= DISPENSE;
               end
            end
            DISPENSE: begin
               if (w_cancel) begin
                  r_status <= ST_CANCEL;
                  r_state  <= ROLLBACK;
               end else if (w_issue) begin
                  for (int i = 0; i < NUM_COIN; i++) begin
                     if (r_idx == IDX_W'(i)) begin
                        r_coin_out[(NUM_COIN-1-i)*CNT_W +: CNT_W] <=
                           r_coin_out[(NUM_COIN-1-i)*CNT_W +: CNT_W] + CNT_W'(1);
                     end
                  end
                  r_change <= r_change - w_cur_val;
               end else if ((r_change == '0) || (r_idx != LAST_IDX)) begin
                  if (r_idx == LAST_IDX) begin
                     r_state      <= DONE;
                     r_vend_valid <= 1'b1;
                     r_p          <= (w_out_sum != r_exp);
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end else begin
                  r_status <= ST_NOCHANGE;
                  r_state  <= ROLLBACK;
               end
            end
            ROLLBACK: begin
               for (int i = 0; i < NUM_COIN; i++) begin
                  r_coin_out[(NUM_COIN-1-i)*CNT_W +: CNT_W] <= CNT_W'(r_coin_in[(NUM_COIN-1-i)*IN_W +: IN_W]);
               end
               r_item_ok    <= 1'b0;
               r_item_out   <= '0;
               r_state      <= DONE;
               r_vend_valid <= 1'b1;
               r_p          <= (w_lat_sum != r_in_val);
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (r_state == IDLE);
   assign vend_valid = r_vend_valid;
   assign item_ok    = r_item_ok;
   assign item_out   = r_item_out;
   assign coin_out   = r_coin_out;
   assign status     = r_status;
   assign p          = r_p;

endmodule

// File: tb/tb_vend_multi_ctrl.sv
// tb_vend_multi_ctrl: directed self-checking bench for vend_multi_ctrl with
// default parameters. Define VEND_CANCEL_EN to exercise the cancel path.
module tb_vend_multi_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_item;
   logic [7:0]  coin_in;
`ifdef VEND_CANCEL_EN
   logic        cancel;
`endif
   logic        vend_valid;
   logic        item_ok;
   logic [1:0]  item_out;
   logic [11:0] coin_out;
   logic [1:0]  status;
   logic        p;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;
   int lat;

   always #5 clk = ~clk;

   vend_multi_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_item   (req_item),
      .coin_in    (coin_in),
`ifdef VEND_CANCEL_EN
      .cancel     (cancel),
`endif
      .vend_valid (vend_valid),
      .item_ok    (item_ok),
      .item_out   (item_out),
      .coin_out   (coin_out),
      .status     (status),
      .p          (p)
   );

   // Inserted counts, order 50/10/5/1.
   function automatic logic [7:0] cin(input int c50, input int c10, input int c5, input int c1);
      return {c50[1:0], c10[1:0], c5[1:0], c1[1:0]};
   endfunction

   // Per-denomination 3-bit counts, order 50/10/5/1.
   function automatic logic [11:0] cnt4(input int c50, input int c10, input int c5, input int c1);
      return {c50[2:0], c10[2:0], c5[2:0], c1[2:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Issue one request and wait (bounded) for vend_valid; lat is the cycle offset from accept.
   task automatic req(input logic [1:0] item, input logic [7:0] cins, output int l);
      req_item  = item;
      coin_in   = cins;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      l = 1;
      while (!vend_valid && l < 60) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_item  = 2'd0;
      coin_in   = 8'd0;
`ifdef VEND_CANCEL_EN
      cancel    = 1'b0;
`endif
      do_reset();

      // Reset state
      chk("rst_ready",  32'(req_ready),  32'd1);
      chk("rst_vvalid", 32'(vend_valid), 32'd0);
      chk("rst_cout",   32'(coin_out),   32'd0);
      chk("rst_itemok", 32'(item_ok),    32'd0);
      chk("rst_itemout",32'(item_out),   32'd0);
      chk("rst_status", 32'(status),     32'd0);
      chk("rst_p",      32'(p),          32'd0);
      chk("rst_stock",  32'(dut.w_stock_flat), 32'(cnt4(2, 2, 2, 2)));

      // Item 0 (cost 8) with one 10: change 2 as two 1-coins
      req(2'd0, cin(0, 1, 0, 0), lat);
      chk("t1_lat",     32'(lat),        32'd8);
      chk("t1_vvalid",  32'(vend_valid), 32'd1);
      chk("t1_itemok",  32'(item_ok),    32'd1);
      chk("t1_itemout", 32'(item_out),   32'd0);
      chk("t1_cout",    32'(coin_out),   32'(cnt4(0, 0, 0, 2)));
      chk("t1_status",  32'(status),     32'd0);
      chk("t1_p",       32'(p),          32'd0);
      chk("t1_stock",   32'(dut.w_stock_flat), 32'(cnt4(2, 3, 2, 0)));
      next_cycle();
      chk("t1_pulse",   32'(vend_valid), 32'd0);
      chk("t1_ready",   32'(req_ready),  32'd1);
      chk("t1_hold",    32'(coin_out),   32'(cnt4(0, 0, 0, 2)));

      // Item 2 (cost 22) with one 10: SHORT, the 10 comes back
      req(2'd2, cin(0, 1, 0, 0), lat);
      chk("t2_lat",     32'(lat),        32'd7);
      chk("t2_status",  32'(status),     32'd1);
      chk("t2_itemok",  32'(item_ok),    32'd0);
      chk("t2_itemout", 32'(item_out),   32'd0);
      chk("t2_cout",    32'(coin_out),   32'(cnt4(0, 1, 0, 0)));
      chk("t2_p",       32'(p),          32'd0);
      chk("t2_stock",   32'(dut.w_stock_flat), 32'(cnt4(2, 3, 2, 0)));
      next_cycle();

      // Item 0 with one 50 after reset: change 42 cannot be made -> refund
      do_reset();
      req(2'd0, cin(1, 0, 0, 0), lat);
      chk("t3_lat",     32'(lat),        32'd13);
      chk("t3_status",  32'(status),     32'd2);
      chk("t3_itemok",  32'(item_ok),    32'd0);
      chk("t3_itemout", 32'(item_out),   32'd0);
      chk("t3_cout",    32'(coin_out),   32'(cnt4(1, 0, 0, 0)));
      chk("t3_p",       32'(p),          32'd0);
      chk("t3_stock",   32'(dut.w_stock_flat), 32'(cnt4(2, 2, 2, 2)));
      next_cycle();

      // Exact-cost purchases pushing the 10-coin stock into saturation
      do_reset();
      req(2'd2, cin(0, 2, 0, 2), lat);
      chk("t4a_lat",    32'(lat),        32'd6);
      chk("t4a_status", 32'(status),     32'd0);
      chk("t4a_itemout",32'(item_out),   32'd2);
      chk("t4a_cout",   32'(coin_out),   32'd0);
      next_cycle();
      req(2'd2, cin(0, 2, 0, 2), lat);
      chk("t4b_stock",  32'(dut.w_stock_flat), 32'(cnt4(2, 6, 2, 6)));
      next_cycle();
      req(2'd1, cin(0, 1, 1, 0), lat);
      chk("t4c_itemok", 32'(item_ok),    32'd1);
      chk("t4c_itemout",32'(item_out),   32'd1);
      chk("t4c_stock",  32'(dut.w_stock_flat), 32'(cnt4(2, 7, 3, 6)));
      next_cycle();
      req(2'd1, cin(0, 1, 1, 0), lat);
      chk("t4d_sat",    32'(dut.w_stock_flat), 32'(cnt4(2, 7, 4, 6)));
      chk("t4d_p",      32'(p),          32'd0);
      next_cycle();

`ifdef VEND_CANCEL_EN
      // Item 1 with two 10s, cancel during DISPENSE at T+3
      do_reset();
      req_item  = 2'd1;
      coin_in   = cin(0, 2, 0, 0);
      req_valid = 1'b1;
      next_cycle();
      req_valid = 1'b0;
      next_cycle();
      next_cycle();
      cancel = 1'b1;
      next_cycle();
      cancel = 1'b0;
      lat = 0;
      while (!vend_valid && lat < 60) begin
         next_cycle();
         lat++;
      end
      chk("t5_vvalid",  32'(vend_valid), 32'd1);
      chk("t5_status",  32'(status),     32'd3);
      chk("t5_itemok",  32'(item_ok),    32'd0);
      chk("t5_cout",    32'(coin_out),   32'(cnt4(0, 2, 0, 0)));
      chk("t5_p",       32'(p),          32'd0);
      chk("t5_stock",   32'(dut.w_stock_flat), 32'(cnt4(2, 2, 2, 2)));
      next_cycle();
`endif

      // Reset in the middle of a dispense
      do_reset();
      req_item  = 2'd0;
      coin_in   = cin(0, 1, 0, 0);
      req_valid = 1'b1;
      next_cycle();
      req_valid = 1'b0;
      next_cycle();
      next_cycle();
      chk("t6_busy",    32'(req_ready),  32'd0);
      chk("t6_accept",  32'(dut.w_stock_flat), 32'(cnt4(2, 3, 2, 2)));
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      chk("t6_ready",   32'(req_ready),  32'd1);
      chk("t6_stock",   32'(dut.w_stock_flat), 32'(cnt4(2, 2, 2, 2)));
      chk("t6_cout",    32'(coin_out),   32'd0);
      chk("t6_vvalid",  32'(vend_valid), 32'd0);
      chk("t6_status",  32'(status),     32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
